store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 109 ++++++++++
 tb/tb_store_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: circular queue of stores draining in order to the data cache.
// Define STORE_BUF_FWD_EN to build store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enq_en,
  input  logic [31:0] enq_addr,
  input  logic [3:0]  enq_sel,
  input  logic [31:0] enq_data,
  output logic        full,
  output logic        empty,
  input  logic        commit_en,
  input  logic        flush,
  output logic        dc_req,
  output logic [3:0]  dc_wen,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  input  logic        dc_ready,
  input  logic [31:0] ld_addr,
  output logic        fwd_hit,
  output logic [3:0]  fwd_sel,
  output logic [31:0] fwd_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] commit_q, commit_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] cnt;
  logic [AW-1:0] hidx;
  logic          do_enq, do_commit, do_drain;

  logic [31:0] addr_q [DEPTH];
  logic [3:0]  sel_q  [DEPTH];
  logic [31:0] data_q [DEPTH];

  assign cnt    = tail_q - head_q;
  assign full   = (cnt == PW'(DEPTH));
  assign empty  = (tail_q == head_q);
  assign dc_req = (head_q != commit_q);
  assign hidx   = head_q[AW-1:0];

  assign dc_wen   = dc_req ? sel_q[hidx]  : 4'h0;
  assign dc_addr  = dc_req ? addr_q[hidx] : 32'h0;
  assign dc_wdata = dc_req ? data_q[hidx] : 32'h0;

  // Flush rewinds tail onto the post-commit pointer, so committed
  // stores (including one mid-handshake) are never lost.
  always_comb begin
    do_enq    = enq_en && !full && !flush;
    do_commit = commit_en && (commit_q != tail_q);
    do_drain  = dc_req && dc_ready;
    head_d    = head_q + PW'(do_drain);
    commit_d  = commit_q + PW'(do_commit);
    tail_d    = flush ? commit_d : tail_q + PW'(do_enq);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      addr_q[tail_q[AW-1:0]] <= enq_addr;
      sel_q[tail_q[AW-1:0]]  <= enq_sel;
      data_q[tail_q[AW-1:0]] <= enq_data;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [PW-1:0] fwd_ptr;

  // Scan oldest to youngest; later matches override earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_sel  = 4'h0;
    fwd_data = 32'h0;
    fwd_ptr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_ptr = head_q + PW'(i);
      if ((PW'(i) < cnt) &&
          (addr_q[fwd_ptr[AW-1:0]][31:2] == ld_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_sel  = sel_q[fwd_ptr[AW-1:0]];
        fwd_data = data_q[fwd_ptr[AW-1:0]];
      end
    end
  end
`else
  logic unused_ld;

  assign unused_ld = ^ld_addr;
  assign fwd_hit   = 1'b0;
  assign fwd_sel   = 4'h0;
  assign fwd_data  = 32'h0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Forwarding expectations follow STORE_BUF_FWD_EN.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        enq_en = 1'b0;
  logic [31:0] enq_addr = '0;
  logic [3:0]  enq_sel = '0;
  logic [31:0] enq_data = '0;
  logic        full, empty;
  logic        commit_en = 1'b0;
  logic        flush = 1'b0;
  logic        dc_req;
  logic [3:0]  dc_wen;
  logic [31:0] dc_addr, dc_wdata;
  logic        dc_ready = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        fwd_hit;
  logic [3:0]  fwd_sel;
  logic [31:0] fwd_data;

  int total = 0;
  int bad = 0;

  store_buffer #(.DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .enq_en(enq_en), .enq_addr(enq_addr),
    .enq_sel(enq_sel), .enq_data(enq_data),
    .full(full), .empty(empty),
    .commit_en(commit_en), .flush(flush),
    .dc_req(dc_req), .dc_wen(dc_wen),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .ld_addr(ld_addr),
    .fwd_hit(fwd_hit), .fwd_sel(fwd_sel),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a,
                     input logic [3:0] s,
                     input logic [31:0] d);
    enq_en = 1'b1; enq_addr = a;
    enq_sel = s; enq_data = d;
    tick();
    enq_en = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    total++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags empty=%b full=%b want 1 0",
               empty, full);
    end
    total++;
    if (dc_req !== 1'b0 || dc_wen !== 4'h0) begin
      bad++;
      $display("FAIL reset_req req=%b wen=%h want 0 0",
               dc_req, dc_wen);
    end
    total++;
    if (dc_addr !== 32'h0 || dc_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_dc addr=%h wdata=%h want 0 0",
               dc_addr, dc_wdata);
    end
    total++;
    if (fwd_hit !== 1'b0 || fwd_sel !== 4'h0 ||
        fwd_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_fwd hit=%b sel=%h data=%h want 0",
               fwd_hit, fwd_sel, fwd_data);
    end
  endtask

  task automatic test_single();
    enq(32'h100, 4'hF, 32'hDEADBEEF);
    total++;
    if (empty !== 1'b0 || dc_req !== 1'b0) begin
      bad++;
      $display("FAIL single_enq empty=%b req=%b want 0 0",
               empty, dc_req);
    end
    commit_en = 1'b1;
    dc_ready = 1'b1;
    tick();
    commit_en = 1'b0;
    total++;
    if (dc_req !== 1'b1 || dc_addr !== 32'h100 ||
        dc_wen !== 4'hF || dc_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_req req=%b a=%h w=%h d=%h",
               dc_req, dc_addr, dc_wen, dc_wdata);
    end
    tick();
    dc_ready = 1'b0;
    total++;
    if (dc_req !== 1'b0 || empty !== 1'b1 ||
        dc_addr !== 32'h0) begin
      bad++;
      $display("FAIL single_done req=%b empty=%b a=%h",
               dc_req, empty, dc_addr);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_a [8];
    int n;
    for (int i = 0; i < 8; i++) begin
      exp_a[i] = 32'h1000 + 32'(i * 4);
      enq(exp_a[i], 4'hF, 32'hA0 + 32'(i));
    end
    total++;
    if (full !== 1'b1) begin
      bad++;
      $display("FAIL full_set full=%b want 1", full);
    end
    enq(32'hBAD0, 4'hF, 32'hBAD);
    total++;
    if (full !== 1'b1 || dc_req !== 1'b0) begin
      bad++;
      $display("FAIL full_ninth full=%b req=%b want 1 0",
               full, dc_req);
    end
    commit_en = 1'b1;
    dc_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      if (dc_req === 1'b1) begin
        total++;
        if (n >= 8 || dc_addr !== exp_a[n]) begin
          bad++;
          $display("FAIL full_order n=%0d addr=%h", n, dc_addr);
        end
        n++;
      end
      tick();
    end
    commit_en = 1'b0;
    dc_ready = 1'b0;
    total++;
    if (n != 8 || empty !== 1'b1) begin
      bad++;
      $display("FAIL full_drain writes=%0d empty=%b want 8 1",
               n, empty);
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp_a [3];
    int n;
    exp_a[0] = 32'h400;
    exp_a[1] = 32'h404;
    exp_a[2] = 32'h408;
    enq(32'h400, 4'hF, 32'h1);
    enq(32'h404, 4'hF, 32'h2);
    enq(32'h408, 4'hF, 32'h3);
    enq(32'h40C, 4'hF, 32'h4);
    commit_en = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    enq_en = 1'b1;
    enq_addr = 32'hF00;
    tick();
    flush = 1'b0;
    enq_en = 1'b0;
    commit_en = 1'b0;
    total++;
    if (dc_req !== 1'b1 || dc_addr !== 32'h400) begin
      bad++;
      $display("FAIL flush_hold req=%b addr=%h want 1 400",
               dc_req, dc_addr);
    end
    dc_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (dc_req === 1'b1) begin
        total++;
        if (n >= 3 || dc_addr !== exp_a[n]) begin
          bad++;
          $display("FAIL flush_order n=%0d addr=%h", n, dc_addr);
        end
        n++;
      end
      tick();
    end
    dc_ready = 1'b0;
    total++;
    if (n != 3 || empty !== 1'b1) begin
      bad++;
      $display("FAIL flush_drain writes=%0d empty=%b want 3 1",
               n, empty);
    end
  endtask

  task automatic test_stall();
    commit_en = 1'b1;
    tick();
    commit_en = 1'b0;
    enq(32'h300, 4'h3, 32'h12345678);
    total++;
    if (dc_req !== 1'b0) begin
      bad++;
      $display("FAIL stray_commit req=%b want 0", dc_req);
    end
    commit_en = 1'b1;
    tick();
    commit_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (dc_req !== 1'b1 || dc_addr !== 32'h300 ||
          dc_wen !== 4'h3 || dc_wdata !== 32'h12345678) begin
        bad++;
        $display("FAIL stall_hold c=%0d req=%b a=%h w=%h d=%h",
                 c, dc_req, dc_addr, dc_wen, dc_wdata);
      end
      tick();
    end
    dc_ready = 1'b1;
    tick();
    dc_ready = 1'b0;
    total++;
    if (dc_req !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL stall_release req=%b empty=%b want 0 1",
               dc_req, empty);
    end
  endtask

  task automatic test_fwd();
    logic        eh;
    logic [3:0]  es;
    logic [31:0] ed;
`ifdef STORE_BUF_FWD_EN
    eh = 1'b1; es = 4'hC; ed = 32'hAAAA0000;
`else
    eh = 1'b0; es = 4'h0; ed = 32'h0;
`endif
    enq(32'h200, 4'hF, 32'h11111111);
    enq(32'h202, 4'hC, 32'hAAAA0000);
    ld_addr = 32'h200;
    #1;
    total++;
    if (fwd_hit !== eh || fwd_sel !== es || fwd_data !== ed) begin
      bad++;
      $display("FAIL fwd_young hit=%b sel=%h data=%h want %b %h %h",
               fwd_hit, fwd_sel, fwd_data, eh, es, ed);
    end
    ld_addr = 32'h204;
    #1;
    total++;
    if (fwd_hit !== 1'b0) begin
      bad++;
      $display("FAIL fwd_miss hit=%b want 0", fwd_hit);
    end
    ld_addr = 32'h0;
  endtask

  task automatic test_reset_mid();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    enq(32'h500, 4'hF, 32'h5);
    enq(32'h504, 4'hF, 32'h6);
    enq(32'h508, 4'hF, 32'h7);
    commit_en = 1'b1;
    tick();
    commit_en = 1'b0;
    tick();
    total++;
    if (dc_req !== 1'b1 || dc_addr !== 32'h500) begin
      bad++;
      $display("FAIL mid_pre req=%b addr=%h want 1 500",
               dc_req, dc_addr);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    total++;
    if (empty !== 1'b1 || dc_req !== 1'b0 ||
        dc_addr !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset empty=%b req=%b addr=%h",
               empty, dc_req, dc_addr);
    end
    tick();
    total++;
    if (dc_req !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL mid_after req=%b empty=%b want 0 1",
               dc_req, empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_flush();
    test_stall();
    test_fwd();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
